ifu_fetch_ctrl: RTL and testbench

Instruction fetch unit for the rvseed multi-cycle core. It holds the architectural PC and fetches one 32-bit instruction per retirement over a simple request/valid instruction-memory port. It presents the fetched word and its PC to the decode stage with one-cycle `ifu_start_en` / `ifu_done_en` strobes. It then waits for the writeback stage to retire the instruction before computing the next PC, which is either sequential or a branch/jump redirect.

---
 rtl/ifu_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: holds the PC, fetches one word per retirement,
// and hands the word plus its PC to decode with one-cycle start/done strobes.
module ifu_fetch_ctrl #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 wb_done_en,
    input  logic                 redirect_en,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 ifu_start_en,
    output logic                 ifu_done_en,
    output logic [CPU_WIDTH-1:0] ifu_inst_pc,
    output logic [CPU_WIDTH-1:0] ifu_inst,
    output logic [1:0]           fsm_state
);

    // Memory handshake: imem_req rises and stays high with imem_addr stable until
    // the first cycle imem_rvalid=1 is seen in FETCH; that cycle completes the transfer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic                 req_d;
    logic                 start_d;
    logic                 done_d;
    logic                 capture;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = imem_req;
        start_d = 1'b0;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    start_d = 1'b1;
                end
            end
            S_FETCH: begin
                // A drop of enable here is deliberately ignored: the fetch always completes.
                if (imem_rvalid) begin
                    capture = 1'b1;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (wb_done_en) begin
                    pc_d = redirect_en ? {redirect_pc[CPU_WIDTH-1:2], 2'b00}
                                       : pc_q + CPU_WIDTH'(4);
                    if (enable) begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            imem_req     <= 1'b0;
            ifu_start_en <= 1'b0;
            ifu_done_en  <= 1'b0;
            ifu_inst     <= '0;
            ifu_inst_pc  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_req     <= req_d;
            ifu_start_en <= start_d;
            ifu_done_en  <= done_d;
            if (capture) begin
                ifu_inst    <= imem_rdata;
                ifu_inst_pc <= pc_q;
            end
        end
    end

    assign imem_addr = pc_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus a randomized instruction stream
// checked against a PC/instruction reference model and an expected-instruction queue.
module tb_ifu_fetch_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0, wb_done_en = 1'b0, redirect_en = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic         imem_req, imem_rvalid = 1'b0;
    logic [W-1:0] imem_addr, imem_rdata = '0;
    logic         ifu_start_en, ifu_done_en;
    logic [W-1:0] ifu_inst_pc, ifu_inst;
    logic [1:0]   fsm_state;

    logic         w_enable = 1'b0, w_wb_done_en = 1'b0, w_imem_rvalid = 1'b0;
    logic [W-1:0] w_imem_rdata = '0;
    logic         w_imem_req, w_ifu_start_en, w_ifu_done_en;
    logic [W-1:0] w_imem_addr, w_ifu_inst_pc, w_ifu_inst;
    logic [1:0]   w_fsm_state;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] model_pc;
    logic [W-1:0] last_inst, last_pc;
    logic [W-1:0] exp_q[$];

    ifu_fetch_ctrl #(.CPU_WIDTH(W), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wb_done_en(wb_done_en),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ifu_start_en(ifu_start_en), .ifu_done_en(ifu_done_en),
        .ifu_inst_pc(ifu_inst_pc), .ifu_inst(ifu_inst), .fsm_state(fsm_state)
    );

    ifu_fetch_ctrl #(.CPU_WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(w_enable), .wb_done_en(w_wb_done_en),
        .redirect_en(1'b0), .redirect_pc(32'h0),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .ifu_start_en(w_ifu_start_en), .ifu_done_en(w_ifu_done_en),
        .ifu_inst_pc(w_ifu_inst_pc), .ifu_inst(w_ifu_inst), .fsm_state(w_fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Entered in the first FETCH cycle; leaves in the cycle after capture.
    task automatic do_fetch(input int waits, input logic [W-1:0] data, input bit inject);
        logic [W-1:0] exp_inst;
        exp_q.push_back(data);
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req_start: got %b want 1", imem_req); end
        n_cmp++; if (ifu_start_en !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b want 1", ifu_start_en); end
        n_cmp++; if (imem_addr !== model_pc) begin n_bad++; $display("FAIL fetch_addr: got %h want %h", imem_addr, model_pc); end
        for (int i = 0; i < waits; i++) begin
            imem_rvalid = 1'b0;
            wb_done_en  = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            redirect_en = inject;
            redirect_pc = $urandom;
            step;
            n_cmp++; if (imem_req !== 1'b1 || ifu_start_en !== 1'b0 || ifu_done_en !== 1'b0) begin
                n_bad++; $display("FAIL wait_strobes: got req=%b start=%b done=%b want 1/0/0", imem_req, ifu_start_en, ifu_done_en);
            end
            n_cmp++; if (imem_addr !== model_pc) begin n_bad++; $display("FAIL addr_stable: got %h want %h", imem_addr, model_pc); end
        end
        wb_done_en  = 1'b0;
        redirect_en = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        exp_inst = exp_q.pop_front();
        n_cmp++; if (ifu_done_en !== 1'b1 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL capture_strobes: got done=%b req=%b want 1/0", ifu_done_en, imem_req);
        end
        n_cmp++; if (ifu_inst !== exp_inst) begin n_bad++; $display("FAIL inst: got %h want %h", ifu_inst, exp_inst); end
        n_cmp++; if (ifu_inst_pc !== model_pc) begin n_bad++; $display("FAIL inst_pc: got %h want %h", ifu_inst_pc, model_pc); end
        last_inst = exp_inst;
        last_pc   = model_pc;
    endtask

    // Entered in the cycle after capture (EXEC); retires after `delay` cycles.
    task automatic retire(input int delay, input bit redir, input logic [W-1:0] rpc, input bit en);
        for (int i = 0; i < delay; i++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            step;
            n_cmp++; if (ifu_done_en !== 1'b0 || imem_req !== 1'b0) begin
                n_bad++; $display("FAIL exec_quiet: got done=%b req=%b want 0/0", ifu_done_en, imem_req);
            end
            n_cmp++; if (ifu_inst !== last_inst || ifu_inst_pc !== last_pc) begin
                n_bad++; $display("FAIL exec_hold: got %h@%h want %h@%h", ifu_inst, ifu_inst_pc, last_inst, last_pc);
            end
        end
        imem_rvalid = 1'b0;
        enable      = en;
        wb_done_en  = 1'b1;
        redirect_en = redir;
        redirect_pc = rpc;
        step;
        wb_done_en  = 1'b0;
        redirect_en = 1'b0;
        model_pc = redir ? {rpc[W-1:2], 2'b00} : model_pc + 32'd4;
        if (!en) begin
            n_cmp++; if (imem_req !== 1'b0 || ifu_start_en !== 1'b0) begin
                n_bad++; $display("FAIL idle_after_retire: got req=%b start=%b want 0/0", imem_req, ifu_start_en);
            end
            n_cmp++; if (imem_addr !== model_pc) begin n_bad++; $display("FAIL idle_pc: got %h want %h", imem_addr, model_pc); end
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b1;
        step;
        step;
        n_cmp++; if (imem_req !== 1'b0 || ifu_start_en !== 1'b0 || ifu_done_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobes: got req=%b start=%b done=%b want 0", imem_req, ifu_start_en, ifu_done_en);
        end
        n_cmp++; if (imem_addr !== 32'h0 || ifu_inst !== 32'h0 || ifu_inst_pc !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got addr=%h inst=%h pc=%h want 0", imem_addr, ifu_inst, ifu_inst_pc);
        end
        n_cmp++; if (w_imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL reset_pc_param: got %h want fffffffc", w_imem_addr); end
        model_pc = 32'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch;
        step;
        do_fetch(0, 32'h0000_0013, 1'b0);
    endtask

    task automatic test_wait_states;
        retire(4, 1'b0, 32'h0, 1'b1);
        do_fetch(3, $urandom, 1'b1);
        retire(4, 1'b0, 32'h0, 1'b1);
        do_fetch(3, $urandom, 1'b1);
    endtask

    task automatic test_redirect;
        retire(2, 1'b1, 32'h0000_0103, 1'b1);
        do_fetch(1, $urandom, 1'b0);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0040;
        step;
        step;
        redirect_en = 1'b0;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== model_pc) begin
            n_bad++; $display("FAIL lone_redirect: got req=%b addr=%h want 0/%h", imem_req, imem_addr, model_pc);
        end
        retire(0, 1'b0, 32'h0, 1'b1);
        do_fetch(0, $urandom, 1'b0);
    endtask

    task automatic test_enable_drop;
        retire(1, 1'b0, 32'h0, 1'b1);
        enable = 1'b0;
        do_fetch(2, $urandom, 1'b0);
        retire(1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step;
            n_cmp++; if (imem_req !== 1'b0 || ifu_start_en !== 1'b0) begin
                n_bad++; $display("FAIL idle_hold: got req=%b start=%b want 0/0", imem_req, ifu_start_en);
            end
        end
        enable = 1'b1;
        step;
        do_fetch(0, $urandom, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            bit en;
            en = ($urandom_range(0, 3) != 0);
            retire($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom, en);
            if (!en) begin
                repeat ($urandom_range(0, 3)) step;
                enable = 1'b1;
                step;
            end
            do_fetch($urandom_range(0, 4), $urandom, 1'b1);
        end
    endtask

    task automatic test_wrap;
        logic [W-1:0] wpc, wdata;
        wpc   = 32'hFFFF_FFFC;
        wdata = $urandom;
        w_enable = 1'b1;
        step;
        n_cmp++; if (w_imem_req !== 1'b1 || w_ifu_start_en !== 1'b1 || w_imem_addr !== wpc) begin
            n_bad++; $display("FAIL wrap_fetch: got req=%b start=%b addr=%h want 1/1/%h", w_imem_req, w_ifu_start_en, w_imem_addr, wpc);
        end
        w_imem_rvalid = 1'b1;
        w_imem_rdata  = wdata;
        step;
        w_imem_rvalid = 1'b0;
        n_cmp++; if (w_ifu_done_en !== 1'b1 || w_ifu_inst !== wdata || w_ifu_inst_pc !== wpc) begin
            n_bad++; $display("FAIL wrap_capture: got done=%b inst=%h pc=%h want 1/%h/%h", w_ifu_done_en, w_ifu_inst, w_ifu_inst_pc, wdata, wpc);
        end
        w_wb_done_en = 1'b1;
        step;
        w_wb_done_en = 1'b0;
        w_enable     = 1'b0;
        wpc = wpc + 32'd4;
        n_cmp++; if (w_imem_req !== 1'b1 || w_imem_addr !== wpc) begin
            n_bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/%h", w_imem_req, w_imem_addr, wpc);
        end
    endtask

    task automatic test_async_reset;
        retire(0, 1'b0, 32'h0, 1'b1);
        enable = 1'b0;
        step;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || ifu_start_en !== 1'b0 || ifu_done_en !== 1'b0) begin
            n_bad++; $display("FAIL async_strobes: got req=%b start=%b done=%b want 0", imem_req, ifu_start_en, ifu_done_en);
        end
        n_cmp++; if (imem_addr !== 32'h0 || ifu_inst !== 32'h0 || ifu_inst_pc !== 32'h0) begin
            n_bad++; $display("FAIL async_data: got addr=%h inst=%h pc=%h want 0", imem_addr, ifu_inst, ifu_inst_pc);
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step;
        step;
        imem_rvalid = 1'b0;
        n_cmp++; if (ifu_done_en !== 1'b0 || imem_req !== 1'b0 || ifu_inst !== 32'h0) begin
            n_bad++; $display("FAIL late_rvalid: got done=%b req=%b inst=%h want 0/0/0", ifu_done_en, imem_req, ifu_inst);
        end
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_wait_states;
        test_redirect;
        test_enable_drop;
        test_random;
        test_wrap;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
